// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the data-RAM load/store front end: defaults, word shift,
// FSM state encoding and the address fault check.
package mem_access_unit_pkg;

  localparam int unsigned MAU_DEPTH  = 20001;
  localparam int unsigned MAU_TAG_W  = 5;
  localparam int unsigned WORD_SHIFT = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // A request faults when it is not word aligned or its word index is past the RAM.
  function automatic logic addr_fault(input logic [31:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ((addr >> WORD_SHIFT) >= depth);
  endfunction

endpackage

// File: rtl/mem_access_unit_resp_hold.sv
// One-entry skid register for a load response; keeps the result stable while
// the consumer stalls so the RAM read port is free again.
module mau_resp_hold #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             sel_hold,
  input  logic [31:0]      live_data,
  input  logic [TAG_W-1:0] live_tag,
  input  logic             live_err,
  output logic [31:0]      data,
  output logic [TAG_W-1:0] tag,
  output logic             err
);

  logic [31:0]      hold_data;
  logic [TAG_W-1:0] hold_tag;
  logic             hold_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data <= '0;
      hold_tag  <= '0;
      hold_err  <= 1'b0;
    end else if (capture) begin
      hold_data <= live_data;
      hold_tag  <= live_tag;
      hold_err  <= live_err;
    end
  end

  assign data = sel_hold ? hold_data : live_data;
  assign tag  = sel_hold ? hold_tag  : live_tag;
  assign err  = sel_hold ? hold_err  : live_err;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the single-port data RAM: address checks, RAM drive,
// load response handshake with a stall hold register, and success counters.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DEPTH = MAU_DEPTH,
  parameter int unsigned TAG_W = MAU_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             err_sticky,
  output logic [31:0]      ld_cnt,
  output logic [31:0]      st_cnt,
  output logic             ram_en,
  output logic             ram_we,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_di,
  input  logic [31:0]      ram_dout
);

  localparam logic [31:0] DEPTH32 = 32'(DEPTH);

  logic [1:0]       state, state_nxt;
  logic             fault, accept, ld_go;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic [31:0]      live_data;
  logic [31:0]      sel_data;
  logic [TAG_W-1:0] sel_tag;
  logic             sel_err;
  logic             busy;

  assign busy      = (state != ST_IDLE);
  assign fault     = addr_fault(req_addr, DEPTH32);
  assign req_ready = !rst && (!busy || resp_ready);
  assign accept    = req_valid && req_ready;
  assign ld_go     = accept && !req_we;

  assign ram_en   = accept && !fault;
  assign ram_we   = ram_en && req_we;
  assign ram_addr = req_addr >> WORD_SHIFT;
  assign ram_di   = req_wdata;

  // A pending response either retires (possibly replaced by a new load) or stalls into HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ld_go ? ST_RD : ST_IDLE;
      ST_RD:   state_nxt = resp_ready ? (ld_go ? ST_RD : ST_IDLE) : ST_HOLD;
      ST_HOLD: state_nxt = resp_ready ? (ld_go ? ST_RD : ST_IDLE) : ST_HOLD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tag_q      <= '0;
      err_q      <= 1'b0;
      err_sticky <= 1'b0;
      ld_cnt     <= '0;
      st_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (ld_go) begin
        tag_q <= req_tag;
        err_q <= fault;
      end
      if (accept && fault) err_sticky <= 1'b1;
      if (ram_en && !req_we) ld_cnt <= ld_cnt + 32'd1;
      if (ram_we) st_cnt <= st_cnt + 32'd1;
    end
  end

  assign live_data = err_q ? 32'd0 : ram_dout;

  mau_resp_hold #(.TAG_W(TAG_W)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .capture   ((state == ST_RD) && !resp_ready),
    .sel_hold  (state == ST_HOLD),
    .live_data (live_data),
    .live_tag  (tag_q),
    .live_err  (err_q),
    .data      (sel_data),
    .tag       (sel_tag),
    .err       (sel_err)
  );

  // Response lines read as zero whenever nothing is being presented.
  assign resp_valid = busy && !rst;
  assign resp_data  = resp_valid ? sel_data : 32'd0;
  assign resp_tag   = resp_valid ? sel_tag  : '0;
  assign resp_err   = resp_valid && sel_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes expected load results
// at acceptance and a negedge monitor compares every presented response.
module tb_mem_access_unit;

  localparam int unsigned DEPTH = 20001;
  localparam int unsigned TAG_W = 5;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we;
  logic [31:0]      req_addr, req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err, err_sticky;
  logic [31:0]      ld_cnt, st_cnt;
  logic             ram_en, ram_we;
  logic [31:0]      ram_addr, ram_di;
  logic [31:0]      ram_dout;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  exp_t        exp_q[$];
  exp_t        front;
  int          compared = 0;
  int          mismatched = 0;
  int unsigned ld_m = 0;
  int unsigned st_m = 0;
  logic        sticky_m = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_err   (resp_err),
    .err_sticky (err_sticky),
    .ld_cnt     (ld_cnt),
    .st_cnt     (st_cnt),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_di     (ram_di),
    .ram_dout   (ram_dout)
  );

  // Behavioural single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en && ram_addr < DEPTH) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of request inputs; on acceptance update the reference model.
  task automatic applyStimulus(input logic v, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [TAG_W-1:0] tag,
                               input logic rr, input int exp_rdy, output logic acc);
    logic        flt;
    logic [31:0] idx;
    exp_t        e;
    req_valid  = v;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_tag    = tag;
    resp_ready = rr;
    @(negedge clk);
    if (exp_rdy >= 0) checkOutput("req_ready", {31'd0, req_ready}, exp_rdy[31:0]);
    acc = v && req_ready;
    idx = addr >> 2;
    flt = (addr[1:0] != 2'b00) || (idx >= DEPTH);
    if (acc) begin
      checkOutput("ram_en", {31'd0, ram_en}, {31'd0, !flt});
      if (!flt) begin
        checkOutput("ram_we", {31'd0, ram_we}, {31'd0, we});
        checkOutput("ram_addr", ram_addr, idx);
        if (we) checkOutput("ram_di", ram_di, wdata);
      end
      if (flt) sticky_m = 1'b1;
      if (we) begin
        if (!flt) begin
          ref_mem[idx] = wdata;
          st_m++;
        end
      end else begin
        e.data = flt ? 32'd0 : ref_mem[idx];
        e.tag  = tag;
        e.err  = flt;
        exp_q.push_back(e);
        if (!flt) ld_m++;
      end
    end else begin
      checkOutput("ram_en_noacc", {31'd0, ram_en}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented response is compared; stalls re-check the same entry.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_resp: got data 0x%0h tag %0d with empty scoreboard", resp_data, resp_tag);
      end else begin
        front = exp_q[0];
        checkOutput("resp_data", resp_data, front.data);
        checkOutput("resp_tag", {27'd0, resp_tag}, {27'd0, front.tag});
        checkOutput("resp_err", {31'd0, resp_err}, {31'd0, front.err});
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    logic pv, pwe, rr, pend;
    logic [31:0] pa, pd;
    logic [TAG_W-1:0] pt;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_tag = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ld_cnt", ld_cnt, 32'd0);
    checkOutput("reset_st_cnt", st_cnt, 32'd0);
    checkOutput("reset_sticky", {31'd0, err_sticky}, 32'd0);
    checkOutput("reset_resp_data", resp_data, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] store then load same address");
    applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 5'd0, 1, 1, acc);
    applyStimulus(1, 0, 32'h10, 32'h0, 5'd3, 1, 1, acc);
    checkOutput("load_latency_valid", {31'd0, resp_valid}, 32'd1);
    applyStimulus(0, 0, 32'h0, 32'h0, 5'd0, 1, 1, acc);
    checkOutput("t1_st_cnt", st_cnt, 32'd1);
    checkOutput("t1_ld_cnt", ld_cnt, 32'd1);

    $display("[TB] back-to-back loads");
    applyStimulus(1, 0, 32'h0, 32'h0, 5'd1, 1, 1, acc);
    applyStimulus(1, 0, 32'h4, 32'h0, 5'd2, 1, 1, acc);
    applyStimulus(1, 0, 32'h8, 32'h0, 5'd4, 1, 1, acc);
    applyStimulus(0, 0, 32'h0, 32'h0, 5'd0, 1, 1, acc);
    checkOutput("t2_ld_cnt", ld_cnt, 32'd4);

    $display("[TB] stalled response with store waiting");
    applyStimulus(1, 0, 32'h4, 32'h0, 5'd7, 1, 1, acc);
    repeat (3) applyStimulus(1, 1, 32'h4, 32'hCAFE0004, 5'd0, 0, 0, acc);
    applyStimulus(1, 1, 32'h4, 32'hCAFE0004, 5'd0, 1, 1, acc);
    applyStimulus(1, 0, 32'h4, 32'h0, 5'd8, 1, 1, acc);
    applyStimulus(0, 0, 32'h0, 32'h0, 5'd0, 1, 1, acc);
    checkOutput("t3_st_cnt", st_cnt, 32'd2);
    checkOutput("t3_ld_cnt", ld_cnt, 32'd6);

    $display("[TB] misaligned load and out-of-range store");
    applyStimulus(1, 0, 32'h6, 32'h0, 5'd9, 1, 1, acc);
    applyStimulus(1, 1, 32'd80004, 32'h12345678, 5'd0, 1, 1, acc);
    applyStimulus(0, 0, 32'h0, 32'h0, 5'd0, 1, 1, acc);
    checkOutput("t4_sticky", {31'd0, err_sticky}, 32'd1);
    checkOutput("t4_st_cnt", st_cnt, 32'd2);
    checkOutput("t4_ld_cnt", ld_cnt, 32'd6);

    $display("[TB] reset with load pending");
    applyStimulus(1, 0, 32'h8, 32'h0, 5'd5, 0, 1, acc);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
    @(negedge clk);
    checkOutput("rstrd_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rstrd_ram_en", {31'd0, ram_en}, 32'd0);
    checkOutput("rstrd_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    ld_m = 0; st_m = 0; sticky_m = 1'b0;
    rst = 1'b0;
    repeat (3) applyStimulus(0, 0, 32'h0, 32'h0, 5'd0, 1, 1, acc);
    checkOutput("rstrd_sticky", {31'd0, err_sticky}, 32'd0);
    checkOutput("rstrd_ld_cnt", ld_cnt, 32'd0);
    checkOutput("rstrd_st_cnt", st_cnt, 32'd0);
    checkOutput("rstrd_resp_tag", {27'd0, resp_tag}, 32'd0);

    $display("[TB] random mix");
    pend = 1'b0;
    pv = 1'b0; pwe = 1'b0; pa = '0; pd = '0; pt = '0;
    for (int i = 0; i < 1000; i++) begin
      if (!pend) begin
        pv  = ($urandom_range(0, 9) < 7);
        pwe = 1'($urandom_range(0, 1));
        pa  = $urandom_range(0, 63) << 2;
        pd  = $urandom;
        pt  = TAG_W'($urandom_range(0, 31));
      end
      rr = ($urandom_range(0, 3) != 0);
      applyStimulus(pv, pwe, pa, pd, pt, rr, -1, acc);
      pend = pv && !acc;
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      applyStimulus(0, 0, 32'h0, 32'h0, 5'd0, 1, 1, acc);
    checkOutput("rand_drained", exp_q.size(), 32'd0);
    checkOutput("rand_ld_cnt", ld_cnt, ld_m);
    checkOutput("rand_st_cnt", st_cnt, st_m);
    checkOutput("rand_sticky", {31'd0, err_sticky}, {31'd0, sticky_m});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end for the core's single-port data RAM, placed between the execute stage and the RAM. It accepts one word request per cycle over a valid/ready handshake and converts the byte address to a word index with alignment and range checks. It drives the RAM enable, write-enable, address and data lines, and returns load data over a second valid/ready handshake. Load data is held while the consumer stalls, so the RAM is free for the next request.

## Interface
Parameters:
- DEPTH, 20001: RAM depth in 32-bit words; the legal word index range is 0..DEPTH-1.
- TAG_W, 5: width of the destination-register tag carried with each load.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when both req_valid and req_ready are 1.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_tag  in  TAG_W  destination tag (loads).
- resp_valid  out  1  load result present.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  32  load data; 0 when resp_err is 1.
- resp_tag  out  TAG_W  tag of the returned load.
- resp_err  out  1  the returned load was misaligned or out of range.
- err_sticky  out  1  set by any faulting request; cleared only by rst.
- ld_cnt, st_cnt  out  32 each  count of successful loads and stores; wrap at 2^32.
- ram_en, ram_we  out  1 each  to the RAM.
- ram_addr  out  32  word index = req_addr >> 2.
- ram_di  out  32  = req_wdata.
- ram_dout  in  32  RAM read data; valid one cycle after ram_en.

## Operation
- Accept = req_valid & req_ready.
- Fault = req_addr[1:0] != 0, or (req_addr >> 2) >= DEPTH. The comparison is unsigned and 32-bit.
- On an accepted request without fault, ram_en = 1 combinationally and ram_we = req_we. ram_addr and ram_di are combinational from the request.
- On an accepted faulting request, ram_en = 0.
- Stores complete at acceptance and produce no response. A faulting store is dropped and sets err_sticky.
- A faulting load still produces a response with resp_err = 1 and resp_data = 0. It also sets err_sticky.
- States:
  - IDLE: no load outstanding. Accepting a load goes to RD; accepting a store stays in IDLE.
  - RD: resp_valid = 1. resp_data = ram_dout for a good load, or 0 for a faulting load. resp_tag and resp_err come from registers.
    - resp_ready = 1: the load retires. The next state is RD if another load is accepted in the same cycle, otherwise IDLE.
    - resp_ready = 0: capture resp_data into the hold register and go to HOLD.
  - HOLD: resp_valid = 1 and resp_data comes from the hold register. On resp_ready = 1, the next state follows the same rule as RD.
- req_ready = 1 in IDLE. In RD and HOLD, req_ready = resp_ready. A store in RD/HOLD with resp_ready = 0 therefore waits.
- ld_cnt increments on each accepted non-faulting load. st_cnt increments on each accepted non-faulting store.
- Reset values: state IDLE, resp_valid 0, resp_data 0, resp_tag 0, resp_err 0, err_sticky 0, ld_cnt 0, st_cnt 0.
- ram_en and ram_we are 0 during reset regardless of req_valid. req_ready is 0 while rst = 1.

## Timing
- Load latency: accepted in cycle N; resp_valid in cycle N+1 at the earliest.
- Throughput: one load per cycle while resp_ready stays 1.
- Store then load to the same address in consecutive cycles returns the new data, because the store is written at the N edge.
- Simultaneous events: a response retires and a new request is accepted in the same cycle with no bubble.
- rst asserted in RD or HOLD discards the pending response, and no resp_valid follows. A request presented during reset is not accepted and not counted.
- A response in HOLD stays stable until taken: resp_data, resp_tag and resp_err do not change while resp_valid & !resp_ready.

## Structure
- The shared package holds:
  - the state enum (IDLE, RD, HOLD);
  - the word-shift constant 2;
  - the default DEPTH and TAG_W.
- One natural sub-module, mau_resp_hold: a one-entry skid register for data, tag and err with a select mux. Address checking, the FSM and the counters live in the top.

## Test plan
- Store 0xDEADBEEF to 0x10, then load 0x10 with tag 3 in the next cycle, resp_ready = 1 → resp_valid in load+1 with data 0xDEADBEEF, tag 3, err 0; st_cnt = 1, ld_cnt = 1.
- Loads to 0x0, 0x4 and 0x8 on back-to-back cycles with resp_ready = 1 → three consecutive responses with data in order, req_ready held at 1.
- Load 0x4, then hold resp_ready = 0 for 3 cycles while a store to 0x4 is presented → resp_data stays at the old value, req_ready = 0, no RAM write until resp_ready = 1.
- Load 0x6 (misaligned), then store to byte address 4*20001 = 80004 (out of range) → load response with resp_err = 1 and data 0; the store produces no ram_en; err_sticky = 1; counters unchanged.
- Load accepted, then rst in the next cycle → no resp_valid afterwards, all outputs at reset values, err_sticky = 0.
- 1000 random aligned in-range load/store mixes with random resp_ready → responses match a scoreboard model, and ld_cnt/st_cnt equal the model counts.
